display_scanner: RTL and testbench
==================================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 SHALL have parameter DIGIT_TICKS, default 50000: clk cycles per digit slot (1 ms at 50 MHz).
REQ-002 SHALL have parameter BLINK_TICKS, default 25000000: clk cycles per colon phase (0.5 s at 50 MHz).
REQ-003 SHALL have port clk  input  1: single clock, rising edge, 50 MHz nominal.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port min0  input  4: minutes units digit from the timer.
REQ-006 SHALL have port min1  input  3: minutes tens digit from the timer.
REQ-007 SHALL have port hour0  input  4: hours units digit from the timer.
REQ-008 SHALL have port hour1  input  2: hours tens digit from the timer.
REQ-009 SHALL have port enable  input  1: high drives the display; low blanks it.
REQ-010 SHALL have port an_n  output  4: active-low digit anodes; an_n[0]=min0, [1]=min1, [2]=hour0, [3]=hour1.
REQ-011 SHALL have port seg_n  output  7: active-low segments {g,f,e,d,c,b,a}.
REQ-012 SHALL have port dp_n  output  1: active-low decimal point, used as the colon.
REQ-013 SHALL have port frame_done  output  1: one-cycle pulse at the end of each 4-digit frame.

Function
REQ-014 SHALL run prescaler 0..DIGIT_TICKS-1, wrapping to 0; the terminal count is the slot tick.
REQ-015 SHALL advance digit index 0->1->2->3->0 on each slot tick.
REQ-016 SHALL latch min0, min1, hour0 and hour1 into a snapshot on the slot tick where the index wraps 3->0, and in the first cycle after reset release; the digits displayed SHALL come only from the snapshot, so each frame is coherent.
REQ-017 SHALL zero-extend min1 and hour1 to 4 bits before decode.
REQ-018 SHALL decode the 4-bit digit value to seg_n as follows: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10; values 10-15 = 0x3F (dash).
REQ-019 SHALL register an_n, seg_n and dp_n; they update together one cycle after the index changes, and an_n SHALL have exactly one bit low when enable=1.
REQ-020 SHALL toggle the colon phase every BLINK_TICKS cycles, using a counter independent of the prescaler.
REQ-021 SHALL drive dp_n low only while index=2 and the colon phase is on; otherwise dp_n=1.
REQ-022 SHALL pulse frame_done high for exactly one cycle, coincident with the 3->0 snapshot latch.
REQ-023 With enable=0, SHALL force an_n=4'hF, seg_n=7'h7F and dp_n=1; counters, snapshot and frame_done SHALL continue running.
REQ-024 When enable rises, SHALL display the current index from the next cycle, with no restart of the frame.

Reset
REQ-025 On rst=0, SHALL immediately set: prescaler=0, index=0, blink counter=0, colon phase=on, snapshot=0, an_n=4'hF, seg_n=7'h7F, dp_n=1, frame_done=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; after release, scanning SHALL restart at index 0 with a fresh snapshot.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN defined: during the index 3 slot, if snapshot hour1=0, SHALL hold an_n=4'hF and seg_n=7'h7F.
REQ-028 Macro LEADING_ZERO_BLANK_EN undefined: hour1=0 SHALL be displayed as 0 (seg_n=0x40) like any other digit.

Verification (DIGIT_TICKS=4, BLINK_TICKS=40 in simulation)
REQ-029 Release reset with inputs 1,2:3,4 (hour1..min0) and enable=1 -> an_n sequence E,D,B,7 every 4 cycles; seg_n 0x19,0x30,0x24,0x79; frame_done pulses every 16 cycles.
REQ-030 Change min0 from 4 to 5 mid-frame -> the current frame still shows 4; 5 appears from the next frame.
REQ-031 Drive min0=12 -> seg_n=0x3F in the index 0 slot.
REQ-032 Check dp_n over 80 cycles -> dp_n is low only in index 2 slots during 40-cycle on phases, and high during off phases.
REQ-033 Drive hour1=0 -> the index 3 slot shows an_n=F with LEADING_ZERO_BLANK_EN defined, and an_n=7 with seg_n=0x40 when it is undefined.
REQ-034 Drop enable for 10 cycles, and separately assert rst mid-slot -> enable low gives blank outputs while frame_done keeps its 16-cycle period; rst gives the REQ-025 values without waiting for a clock edge, and scanning restarts at index 0.

Source files
------------

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - 4-digit multiplexed 7-segment scanner with blinking colon.
// Define LEADING_ZERO_BLANK_EN to blank the hours-tens digit when it is zero.
module display_scanner #(
   parameter int DIGIT_TICKS = 50000,
   parameter int BLINK_TICKS = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] min0,
   input  logic [2:0] min1,
   input  logic [3:0] hour0,
   input  logic [1:0] hour1,
   input  logic       enable,
   output logic [3:0] an_n,
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic       frame_done
);

   localparam int PW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZ_BLANK = 1'b1;
`else
   localparam bit LZ_BLANK = 1'b0;
`endif

   logic [PW-1:0] presc_q, presc_d;
   logic [BW-1:0] blink_q, blink_d;
   logic [1:0]    idx_q, idx_d;
   logic          colon_q, colon_d;
   logic          first_q;
   logic [3:0]    snap_m0_q, snap_h0_q;
   logic [2:0]    snap_m1_q;
   logic [1:0]    snap_h1_q;
   logic [3:0]    an_d;
   logic [6:0]    seg_d, seg_dec;
   logic          dp_d;
   logic          slot_tick, frame_tick, snap_en;
   logic [3:0]    digit;

   always_comb begin
      slot_tick  = (presc_q == PW'(DIGIT_TICKS - 1));
      frame_tick = slot_tick && (idx_q == 2'd3);
      // The snapshot also loads on the first cycle after reset so frame 0 is valid.
      snap_en    = frame_tick || first_q;
      presc_d    = slot_tick ? '0 : presc_q + 1'b1;
      idx_d      = slot_tick ? idx_q + 2'd1 : idx_q;
      if (blink_q == BW'(BLINK_TICKS - 1)) begin
         blink_d = '0;
         colon_d = ~colon_q;
      end else begin
         blink_d = blink_q + 1'b1;
         colon_d = colon_q;
      end
   end

   always_comb begin
      case (idx_q)
         2'd0:    digit = snap_m0_q;
         2'd1:    digit = {1'b0, snap_m1_q};
         2'd2:    digit = snap_h0_q;
         default: digit = {2'b00, snap_h1_q};
      endcase
      case (digit)
         4'd0:    seg_dec = 7'h40;
         4'd1:    seg_dec = 7'h79;
         4'd2:    seg_dec = 7'h24;
         4'd3:    seg_dec = 7'h30;
         4'd4:    seg_dec = 7'h19;
         4'd5:    seg_dec = 7'h12;
         4'd6:    seg_dec = 7'h02;
         4'd7:    seg_dec = 7'h78;
         4'd8:    seg_dec = 7'h00;
         4'd9:    seg_dec = 7'h10;
         default: seg_dec = 7'h3F;
      endcase
      an_d  = 4'hF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (enable) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = seg_dec;
         dp_d  = !((idx_q == 2'd2) && colon_q);
         if (LZ_BLANK && (idx_q == 2'd3) && (snap_h1_q == 2'd0)) begin
            an_d  = 4'hF;
            seg_d = 7'h7F;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q    <= '0;
         idx_q      <= 2'd0;
         blink_q    <= '0;
         colon_q    <= 1'b1;
         first_q    <= 1'b1;
         snap_m0_q  <= 4'd0;
         snap_m1_q  <= 3'd0;
         snap_h0_q  <= 4'd0;
         snap_h1_q  <= 2'd0;
         an_n       <= 4'hF;
         seg_n      <= 7'h7F;
         dp_n       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         blink_q    <= blink_d;
         colon_q    <= colon_d;
         first_q    <= 1'b0;
         if (snap_en) begin
            snap_m0_q <= min0;
            snap_m1_q <= min1;
            snap_h0_q <= hour0;
            snap_h1_q <= hour1;
         end
         an_n       <= an_d;
         seg_n      <= seg_d;
         dp_n       <= dp_d;
         frame_done <= frame_tick;
      end
   end

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - directed self-checking bench for display_scanner.
module tb_display_scanner;

   logic       clk;
   logic       rst;
   logic [3:0] min0;
   logic [2:0] min1;
   logic [3:0] hour0;
   logic [1:0] hour1;
   logic       enable;
   logic [3:0] an_n;
   logic [6:0] seg_n;
   logic       dp_n;
   logic       frame_done;

   int errors = 0;
   int checks = 0;

   logic [3:0] s_m0, s_h0;
   logic [2:0] s_m1;
   logic [1:0] s_h1;

   display_scanner #(.DIGIT_TICKS(4), .BLINK_TICKS(40)) dut (
      .clk(clk), .rst(rst), .min0(min0), .min1(min1), .hour0(hour0), .hour1(hour1),
      .enable(enable), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] exp_seg(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   task automatic chk(input string tag, input int n, input logic [6:0] obs, input logic [6:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
      end
   endtask

   // Sample after edge n; the outputs reflect index/snapshot/colon as they stood before edge n.
   task automatic step(input int n);
      int          idx;
      logic [3:0]  d;
      logic [3:0]  e_an;
      logic [6:0]  e_seg;
      logic        e_dp;
      logic        colon;
      @(negedge clk);
      idx   = ((n - 1) / 4) % 4;
      colon = (((n - 1) / 40) % 2) == 0;
      case (idx)
         0: d = s_m0;
         1: d = {1'b0, s_m1};
         2: d = s_h0;
         default: d = {2'b00, s_h1};
      endcase
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (enable) begin
         e_an  = ~(4'b0001 << idx);
         e_seg = exp_seg(d);
         e_dp  = !(idx == 2 && colon);
`ifdef LEADING_ZERO_BLANK_EN
         if (idx == 3 && s_h1 == 2'd0) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
         end
`endif
      end
      chk("an_n", n, {3'b0, an_n}, {3'b0, e_an});
      chk("seg_n", n, seg_n, e_seg);
      chk("dp_n", n, {6'b0, dp_n}, {6'b0, e_dp});
      chk("frame_done", n, {6'b0, frame_done}, {6'b0, (n % 16) == 0});
      if (n == 1 || (n % 16) == 0) begin
         s_m0 = min0;
         s_m1 = min1;
         s_h0 = hour0;
         s_h1 = hour1;
      end
   endtask

   initial begin
      rst = 1'b0; enable = 1'b1;
      hour1 = 2'd1; hour0 = 4'd2; min1 = 3'd3; min0 = 4'd4;
      s_m0 = 4'd0; s_m1 = 3'd0; s_h0 = 4'd0; s_h1 = 2'd0;
      #12;
      chk("rst_an_n", 0, {3'b0, an_n}, 7'h0F);
      chk("rst_seg_n", 0, seg_n, 7'h7F);
      chk("rst_dp_n", 0, {6'b0, dp_n}, 7'h01);
      chk("rst_frame_done", 0, {6'b0, frame_done}, 7'h00);
      @(negedge clk);
      rst = 1'b1;
      for (int n = 1; n <= 180; n++) begin
         step(n);
         if (n == 82)  min0 = 4'd5;
         if (n == 100) min0 = 4'd12;
         if (n == 120) hour1 = 2'd0;
         if (n == 150) enable = 1'b0;
         if (n == 160) enable = 1'b1;
      end
      // Asynchronous reset mid-slot, checked before any clock edge.
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_an_n", 0, {3'b0, an_n}, 7'h0F);
      chk("async_seg_n", 0, seg_n, 7'h7F);
      chk("async_dp_n", 0, {6'b0, dp_n}, 7'h01);
      chk("async_frame_done", 0, {6'b0, frame_done}, 7'h00);
      hour1 = 2'd2; hour0 = 4'd1; min1 = 3'd5; min0 = 4'd9;
      s_m0 = 4'd0; s_m1 = 3'd0; s_h0 = 4'd0; s_h1 = 2'd0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int n = 1; n <= 34; n++) begin
         step(n);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
